// File: rtl/med_ctrl.sv
// Sequencer for the 9-pixel MED median datapath: loads a window, runs discard-max passes, returns the median.
// Optional MED_CTRL_OVERLAP_EN: result slot decoupled from the FSM so the next frame can load while RES waits.
module med_ctrl #(
  parameter int NPIX  = 9,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pix_in_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [WIDTH-1:0] med_di_o,
  output logic             med_dsi_o,
  output logic             med_byp_o,
  input  logic [WIDTH-1:0] med_do_i,
  output logic [WIDTH-1:0] res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic             err_o
);

  // state | meaning
  // IDLE  | waiting for the first beat of a burst
  // LOAD  | shifting the window into the MED ring, one pixel per cycle
  // CMP   | ring rotates, DO accumulates the max of all slots
  // DISC  | max discarded from DO, a zero shifted into the ring
  // CAPT  | median sits in DO, copied into RES
  // HOLD  | RES offered to the sink (default build only)
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_DISC,
    S_CAPT
`ifndef MED_CTRL_OVERLAP_EN
    , S_HOLD
`endif
  } state_t;

  localparam int         NPASS     = (NPIX - 1) / 2;
  localparam logic [3:0] LOAD_LAST = 4'(NPIX - 1);
  localparam logic [3:0] CMP_LAST  = 4'(NPIX - 2);
  localparam logic [2:0] PASS_LAST = 3'(NPASS);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2:0]         pass_q, pass_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic               err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pass_q      <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    err_d       = 1'b0;
`ifdef MED_CTRL_OVERLAP_EN
    // Result slot handshakes independently of the sequencer.
    if (res_valid_q && res_ready_i) res_valid_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pix_valid_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (!pix_valid_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LOAD_LAST) begin
          state_d = S_CMP;
          cnt_d   = '0;
          pass_d  = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CMP: begin
        if (cnt_q == CMP_LAST) begin
          cnt_d   = '0;
          state_d = (pass_q < PASS_LAST) ? S_DISC : S_CAPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DISC: begin
        pass_d  = pass_q + 3'd1;
        state_d = S_CMP;
      end
      S_CAPT: begin
`ifdef MED_CTRL_OVERLAP_EN
        // DO keeps the median while the ring idles, so waiting here is safe.
        if (!res_valid_q || res_ready_i) begin
          res_d       = med_do_i;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
`else
        res_d       = med_do_i;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
`endif
      end
`ifndef MED_CTRL_OVERLAP_EN
      S_HOLD: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign pix_ready_o = (state_q == S_LOAD);
  assign med_dsi_o   = (state_q == S_LOAD) || (state_q == S_DISC);
  assign med_byp_o   = (state_q == S_LOAD) || (state_q == S_DISC);
  assign med_di_o    = (state_q == S_LOAD) ? pix_in_i : '0;
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_med_ctrl.sv
// Bench for med_ctrl: behavioural MED ring model as the datapath, sorted-window median scoreboard.
module tb_med_ctrl;

  typedef logic [7:0] win_t [9];

  logic       clk;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] med_di;
  logic       med_dsi;
  logic       med_byp;
  logic [7:0] med_do;
  logic [7:0] res;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int load_start = 0;
  int rv_cycle   = 0;
  bit rnd_ready  = 0;
  bit ready_level = 1;
  logic [7:0] exp_q [$];

  logic [7:0] ring [8];
  logic [7:0] prev_res;
  bit         prev_hold = 0;

  med_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pix_in_i    (pix_in),
    .pix_valid_i (pix_valid),
    .pix_ready_o (pix_ready),
    .med_di_o    (med_di),
    .med_dsi_o   (med_dsi),
    .med_byp_o   (med_byp),
    .med_do_i    (med_do),
    .res_o       (res),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // MED datapath: DSI picks R0 source (DI / min), BYP picks DO source (R7 / max).
  initial begin
    for (int i = 0; i < 8; i++) ring[i] = 8'd0;
    med_do = 8'd0;
  end

  always @(posedge clk) begin
    logic [7:0] hi, lo;
    hi = (ring[7] > med_do) ? ring[7] : med_do;
    lo = (ring[7] > med_do) ? med_do : ring[7];
    for (int i = 7; i > 0; i--) ring[i] <= ring[i-1];
    ring[0] <= med_dsi ? med_di : lo;
    med_do  <= med_byp ? ring[7] : hi;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  function automatic logic [7:0] median(input win_t w);
    win_t s;
    logic [7:0] t;
    s = w;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Scoreboard: every accepted result must match the next expected median; held results stay put.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("res_stable", res, prev_res);
        check("res_valid_held", res_valid, 1);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_unexpected actual=%0d required=none", res);
        end else begin
          check("res_model", res, exp_q.pop_front());
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_res  = res;
    end
  end

  task automatic send_burst(input win_t px, input int brk);
    int t;
    for (int i = 0; i < 9; i++) begin
      if (i == brk) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
        check("err_pulse", err, 1);
        check("err_idle", busy, 0);
        check("err_no_res", res_valid, 0);
        @(posedge clk); #1;
        check("err_one_cycle", err, 0);
        return;
      end
      pix_valid = 1'b1;
      pix_in    = px[i];
      t = 0;
      while (!pix_ready && t < 400) begin
        @(posedge clk); #1;
        t++;
      end
      if (!pix_ready) begin
        total++;
        bad++;
        $display("FAIL load_timeout actual=no_ready required=ready beat=%0d", i);
        pix_valid = 1'b0;
        return;
      end
      if (i == 0) load_start = cyc;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    exp_q.push_back(median(px));
  endtask

  task automatic wait_result(input string name, input logic [7:0] expv);
    int t;
    t = 0;
    while (!res_valid && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    rv_cycle = cyc;
    check({name, "_valid"}, res_valid, 1);
    check(name, res, expv);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || res_valid || busy) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    win_t w;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res", res, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_dsi", med_dsi, 0);
    check("rst_byp", med_byp, 0);
    check("rst_di", med_di, 0);
    check("rst_pix_ready", pix_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: ascending burst, latency and return to idle
    ready_level = 1;
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    send_burst(w, 99);
    check("load_dsi_off", med_dsi, 0);
    wait_result("t1_res", 8'd5);
    check("t1_latency", rv_cycle - load_start, 54);
    @(posedge clk); #1;
    check("t1_busy_after", busy, 0);

    // 2: duplicates and extremes
    w = '{8'd7, 8'd7, 8'd7, 8'd0, 8'd255, 8'd255, 8'd3, 8'd7, 8'd200};
    send_burst(w, 99);
    wait_result("t2_mixed", 8'd7);
    w = '{default: 8'd255};
    send_burst(w, 99);
    wait_result("t2_all255", 8'd255);
    w = '{default: 8'd0};
    send_burst(w, 99);
    wait_result("t2_all0", 8'd0);
    drain();

    // 3: broken burst, then a clean one
    w = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
    send_burst(w, 4);
    repeat (60) @(posedge clk);
    #1;
    check("t3_no_res", res_valid, 0);
    w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_burst(w, 99);
    wait_result("t3_res", 8'd5);
    drain();

    // 4: sink stall
    ready_level = 0;
    w = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd2, 8'd8, 8'd4, 8'd6};
    send_burst(w, 99);
    wait_result("t4_res", 8'd5);
`ifdef MED_CTRL_OVERLAP_EN
    w = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'd140, 8'd160, 8'd180};
    send_burst(w, 99);
    repeat (60) begin
      @(posedge clk); #1;
      check("t4_ovl_res_stable", res, 5);
    end
    ready_level = 1;
`else
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    repeat (20) begin
      @(posedge clk); #1;
      check("t4_pix_ready_low", pix_ready, 0);
      check("t4_res_hold", res, 5);
    end
    pix_valid   = 1'b0;
    ready_level = 1;
`endif
    drain();

    // 5: reset during pass 2
    w = '{8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd10, 8'd20, 8'd30, 8'd40};
    send_burst(w, 99);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_res", res, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_err", err, 0);
    check("t5_dsi", med_dsi, 0);
    check("t5_byp", med_byp, 0);
    check("t5_di", med_di, 0);
    check("t5_pix_ready", pix_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    w = '{default: 8'd100};
    send_burst(w, 99);
    wait_result("t5_res_after", 8'd100);
    drain();

    // 6: random windows, random sink readiness
    rnd_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 9; k++) begin
        if (mode == 0)      w[k] = 8'($urandom_range(0, 255));
        else if (mode == 1) w[k] = 8'($urandom_range(0, 3));
        else                w[k] = 8'($urandom_range(250, 255));
      end
      send_burst(w, 99);
    end
    drain();
    rnd_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
